regfile_wb_arbiter: RTL



---
 rtl/regfile_wb_arbiter_pkg.sv | 28 ++
 rtl/regfile_wb_arbiter_fifo.sv | 69 ++++++
 rtl/regfile_wb_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//
// Purpose : default parameter values for the arbiter and its result FIFO,
//           the write-port source encoding, and a width helper.
// Ports   : none (package).
package regfile_wb_arbiter_pkg;

    localparam int RS_WIDTH       = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_SIZE       = 1 << RS_WIDTH;
    localparam int WB_QDEPTH      = 2;
    localparam int WB_STARVE_MAX  = 4;

    // Which source owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_e;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_fifo: synchronous FIFO of {rd, data} pairs for long-latency results.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (pointers/count only)
//   push, push_rd,
//   push_data           enqueue request and payload (caller guarantees !full)
//   pop                 dequeue the head (caller guarantees !empty)
//   full, empty         occupancy flags from the registered count
//   head_rd, head_data  oldest entry
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int RS_WIDTH   = regfile_wb_arbiter_pkg::RS_WIDTH,
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int DEPTH      = WB_QDEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [RS_WIDTH-1:0]   push_rd,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [RS_WIDTH-1:0]   head_rd,
    output logic [DATA_WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [RS_WIDTH-1:0]   rd_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale contents are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= push_rd;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign head_rd   = rd_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register-file write port between the
// in-order pipeline writeback and a long-latency unit (LU). LU results are
// queued in wb_fifo and drained in cycles the pipeline does not write. A busy
// scoreboard flags registers with an outstanding LU write.
//
// Build option: define RISCV_WB_STARVE_EN to enable the starvation counter,
// which holds the pipeline for one cycle after STARVE_MAX consecutive blocked
// cycles so the FIFO head can write. Without it pipe_hold is tied 0 and the
// FIFO drains only in pipeline-idle cycles.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   pipe_valid/pipe_rd/pipe_data pipeline writeback request
//   pipe_hold                   pipeline write not taken; re-present it
//   lu_valid/lu_rd/lu_data      LU result, accepted when lu_valid && lu_ready
//   lu_ready                    FIFO has room (registered occupancy)
//   issue_valid/issue_rd        LU operation issued; marks issue_rd busy
//   rs1/rs2, rs1_busy/rs2_busy  decode-stage sources and their pending status
//   rf_we/rf_rd/rf_wdata        register-file write port
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int RS_WIDTH   = regfile_wb_arbiter_pkg::RS_WIDTH,
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int QDEPTH     = WB_QDEPTH,
    parameter int STARVE_MAX = WB_STARVE_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_valid,
    input  logic [RS_WIDTH-1:0]   pipe_rd,
    input  logic [DATA_WIDTH-1:0] pipe_data,
    output logic                  pipe_hold,
    input  logic                  lu_valid,
    output logic                  lu_ready,
    input  logic [RS_WIDTH-1:0]   lu_rd,
    input  logic [DATA_WIDTH-1:0] lu_data,
    input  logic                  issue_valid,
    input  logic [RS_WIDTH-1:0]   issue_rd,
    input  logic [RS_WIDTH-1:0]   rs1,
    input  logic [RS_WIDTH-1:0]   rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rf_we,
    output logic [RS_WIDTH-1:0]   rf_rd,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int NREGS = 1 << RS_WIDTH;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [RS_WIDTH-1:0]   head_rd;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  push;
    logic                  pop;
    logic                  init_done;
    logic                  pipe_req;
    logic                  pipe_grant;
    wb_src_e               src;
    logic [NREGS-1:0]      busy;
    logic [NREGS-1:0]      busy_next;

    // Keeps lu_ready low for the first cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) init_done <= 1'b0;
        else     init_done <= 1'b1;
    end

    // ---- LU accept ----
    assign lu_ready = init_done && !rst && !fifo_full;
    // Results for x0 are acknowledged but never stored.
    assign push     = lu_valid && lu_ready && (lu_rd != '0);

    wb_fifo #(
        .RS_WIDTH   (RS_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rd   (lu_rd),
        .push_data (lu_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_rd   (head_rd),
        .head_data (head_data)
    );

    // ---- Starvation control ----
`ifdef RISCV_WB_STARVE_EN
    localparam int CW = cnt_width(STARVE_MAX);

    logic [CW-1:0] starve_cnt;

    // Counts consecutive cycles the pipeline won while the FIFO waited.
    always_ff @(posedge clk) begin
        if (rst || fifo_empty || pop) starve_cnt <= '0;
        else if (pipe_grant)          starve_cnt <= starve_cnt + CW'(1);
    end

    assign pipe_hold = !rst && !fifo_empty && (starve_cnt == CW'(STARVE_MAX));
`else
    assign pipe_hold = 1'b0;
`endif

    // ---- Write-port arbitration ----
    // A pipeline write to x0 is not a request, so it never blocks the FIFO.
    assign pipe_req   = !rst && pipe_valid && (pipe_rd != '0);
    assign pipe_grant = pipe_req && !pipe_hold;

    always_comb begin
        src = SRC_NONE;
        if (pipe_grant)                src = SRC_PIPE;
        else if (!rst && !fifo_empty)  src = SRC_FIFO;
    end

    assign pop = (src == SRC_FIFO);

    always_comb begin
        rf_we    = 1'b0;
        rf_rd    = '0;
        rf_wdata = '0;
        case (src)
            SRC_PIPE: begin
                rf_we    = 1'b1;
                rf_rd    = pipe_rd;
                rf_wdata = pipe_data;
            end
            SRC_FIFO: begin
                rf_we    = 1'b1;
                rf_rd    = head_rd;
                rf_wdata = head_data;
            end
            default: ;
        endcase
    end

    // ---- Busy scoreboard ----
    // Set is applied after clear so a same-index issue in the pop cycle wins.
    always_comb begin
        busy_next = busy;
        if (pop)                             busy_next[head_rd]  = 1'b0;
        if (issue_valid && issue_rd != '0)   busy_next[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

    assign rs1_busy = !rst && (rs1 != '0) && busy[rs1];
    assign rs2_busy = !rst && (rs2 != '0) && busy[rs2];

endmodule
